control_pipeline: RTL and testbench

- Parametrised pipelined control unit for the RISC-V core. Decodes the ID-stage opcode into a control bundle and carries it through EX, MEM and WB registers.
- Handles hazard-unit stalls (bubble insertion), branch/jump flushes, optional U-type decode, illegal-opcode flagging, and a halt drain FSM. The FSM stops fetch and signals completion once every instruction older than HALT has retired.
- Sits between the IF/ID register and the datapath stage registers.

---
 rtl/ctrl_pkg.sv | 40 ++++
 rtl/control_pipeline_if.sv | 32 +++
 rtl/control_decode.sv | 63 ++++++
 rtl/control_pipeline.sv | 89 ++++++++
 tb/tb_control_pipeline.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and opcode constants for the pipelined control unit.
package ctrl_pkg;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  typedef enum logic [1:0] {
    AluLdst   = 2'b00,
    AluBranch = 2'b01,
    AluRtype  = 2'b10,
    AluUtype  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    alu_src;
    alu_op_e alu_op;
    logic    branch;
    logic    jal;
    logic    jalr;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    reg_write;
    logic    illegal;
  } ctrl_bundle_t;

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StDrain  = 2'b01,
    StHalted = 2'b10
  } halt_state_e;

endpackage

// File: rtl/control_pipeline_if.sv
// ID-side inputs and per-stage control taps of the control pipeline.
interface control_pipeline_if;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic       stall;
  logic       flush;
  logic       ex_alu_src;
  logic [1:0] ex_alu_op;
  logic       ex_branch;
  logic       ex_jal;
  logic       ex_jalr;
  logic       ex_mem_read;
  logic       ex_illegal;
  logic       mem_mem_read;
  logic       mem_mem_write;
  logic       wb_reg_write;
  logic       wb_mem_to_reg;
  logic       fetch_en;
  logic       halted;

  modport master (
    output id_valid, id_opcode, stall, flush,
    input  ex_alu_src, ex_alu_op, ex_branch, ex_jal, ex_jalr, ex_mem_read, ex_illegal,
    input  mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, fetch_en, halted
  );

  modport slave (
    input  id_valid, id_opcode, stall, flush,
    output ex_alu_src, ex_alu_op, ex_branch, ex_jal, ex_jalr, ex_mem_read, ex_illegal,
    output mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, fetch_en, halted
  );
endinterface

// File: rtl/control_decode.sv
// Combinational opcode to control-bundle decoder.
module control_decode
  import ctrl_pkg::*;
#(
  parameter bit         EN_UTYPE    = 1'b1,
  parameter logic [6:0] HALT_OPCODE = 7'b1111111
) (
  input  logic [6:0]   opcode_i,
  output ctrl_bundle_t bundle_o
);

  always_comb begin
    bundle_o = '0;
    // HALT takes priority so it can never be flagged illegal.
    if (opcode_i != HALT_OPCODE) begin
      case (opcode_i)
        OpR: begin
          bundle_o.reg_write = 1'b1;
          bundle_o.alu_op    = AluRtype;
        end
        OpI: begin
          bundle_o.reg_write = 1'b1;
          bundle_o.alu_src   = 1'b1;
          bundle_o.alu_op    = AluRtype;
        end
        OpLoad: begin
          bundle_o.reg_write  = 1'b1;
          bundle_o.alu_src    = 1'b1;
          bundle_o.mem_read   = 1'b1;
          bundle_o.mem_to_reg = 1'b1;
        end
        OpStore: begin
          bundle_o.alu_src   = 1'b1;
          bundle_o.mem_write = 1'b1;
        end
        OpBr: begin
          bundle_o.branch = 1'b1;
          bundle_o.alu_op = AluBranch;
        end
        OpJal: begin
          bundle_o.jal       = 1'b1;
          bundle_o.reg_write = 1'b1;
        end
        OpJalr: begin
          bundle_o.jalr      = 1'b1;
          bundle_o.reg_write = 1'b1;
          bundle_o.alu_src   = 1'b1;
        end
        OpLui, OpAuipc: begin
          if (EN_UTYPE) begin
            bundle_o.reg_write = 1'b1;
            bundle_o.alu_src   = 1'b1;
            bundle_o.alu_op    = AluUtype;
          end else begin
            bundle_o.illegal = 1'b1;
          end
        end
        default: bundle_o.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/control_pipeline.sv
// Control bundle pipeline (EX..WB) with stall bubbles, flush, and a HALT drain FSM.
module control_pipeline
  import ctrl_pkg::*;
#(
  parameter int unsigned N_STAGES    = 3,
  parameter int unsigned MEM_IDX     = 1,
  parameter bit          EN_UTYPE    = 1'b1,
  parameter logic [6:0]  HALT_OPCODE = 7'b1111111
) (
  input  logic               clk,
  input  logic               reset_n,
  control_pipeline_if.slave  bus
);

  localparam int unsigned CntW = $clog2(N_STAGES + 1);

  ctrl_bundle_t decoded;
  ctrl_bundle_t stage_q [N_STAGES];
  ctrl_bundle_t stage_d [N_STAGES];
  halt_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic         accept;

  control_decode #(
    .EN_UTYPE    (EN_UTYPE),
    .HALT_OPCODE (HALT_OPCODE)
  ) u_decode (
    .opcode_i (bus.id_opcode),
    .bundle_o (decoded)
  );

  assign accept = bus.id_valid & ~bus.stall & ~bus.flush & (state_q == StRun);

  // The pipe always advances; a rejected ID slot becomes a zero bubble.
  always_comb begin
    stage_d[0] = accept ? decoded : '0;
    for (int unsigned k = 1; k < N_STAGES; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (accept && (bus.id_opcode == HALT_OPCODE)) begin
          state_d = StDrain;
          cnt_d   = CntW'(N_STAGES);
        end
      end
      StDrain: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StHalted;
      end
      StHalted: ;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < N_STAGES; k++) begin
        stage_q[k] <= '0;
      end
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ex_alu_src    = stage_q[0].alu_src;
  assign bus.ex_alu_op     = stage_q[0].alu_op;
  assign bus.ex_branch     = stage_q[0].branch;
  assign bus.ex_jal        = stage_q[0].jal;
  assign bus.ex_jalr       = stage_q[0].jalr;
  assign bus.ex_mem_read   = stage_q[0].mem_read;
  assign bus.ex_illegal    = stage_q[0].illegal;
  assign bus.mem_mem_read  = stage_q[MEM_IDX].mem_read;
  assign bus.mem_mem_write = stage_q[MEM_IDX].mem_write;
  assign bus.wb_reg_write  = stage_q[N_STAGES-1].reg_write;
  assign bus.wb_mem_to_reg = stage_q[N_STAGES-1].mem_to_reg;
  assign bus.fetch_en      = (state_q == StRun);
  assign bus.halted        = (state_q == StHalted);

endmodule

// File: tb/tb_control_pipeline.sv
// Directed scoreboard bench for control_pipeline (N_STAGES=3, MEM_IDX=1).
module tb_control_pipeline;

  localparam int N = 3;
  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] HALT = 7'b1111111;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] op;
    logic       br, jal, jalr, mr, mw, m2r, rw, ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  control_pipeline_if bus ();
  control_pipeline_if bus0 ();

  control_pipeline #(
    .N_STAGES(N), .MEM_IDX(1), .EN_UTYPE(1'b1), .HALT_OPCODE(HALT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  control_pipeline #(
    .N_STAGES(N), .MEM_IDX(1), .EN_UTYPE(1'b0), .HALT_OPCODE(HALT)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave)
  );

  exp_t sb[$];
  int   ntests = 0;
  int   nfail  = 0;
  bit   in_run = 1'b1;
  int   stepn  = 0;
  int   hstep  = 0;

  function automatic exp_t dec(logic [6:0] o);
    exp_t e = '0;
    case (o)
      ADD:  begin e.rw = 1; e.op = 2'b10; end
      ADDI: begin e.rw = 1; e.alu_src = 1; e.op = 2'b10; end
      LW:   begin e.rw = 1; e.alu_src = 1; e.mr = 1; e.m2r = 1; end
      SW:   begin e.alu_src = 1; e.mw = 1; end
      BEQ:  begin e.br = 1; e.op = 2'b01; end
      JAL:  begin e.jal = 1; e.rw = 1; end
      JALR: begin e.jalr = 1; e.rw = 1; e.alu_src = 1; end
      LUI, 7'b0010111: begin e.rw = 1; e.alu_src = 1; e.op = 2'b11; end
      HALT: e = '0;
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  function automatic logic [7:0] ex_obs();
    return {bus.ex_alu_src, bus.ex_alu_op, bus.ex_branch, bus.ex_jal, bus.ex_jalr,
            bus.ex_mem_read, bus.ex_illegal};
  endfunction

  function automatic logic [7:0] ex_obs0();
    return {bus0.ex_alu_src, bus0.ex_alu_op, bus0.ex_branch, bus0.ex_jal, bus0.ex_jalr,
            bus0.ex_mem_read, bus0.ex_illegal};
  endfunction

  function automatic logic [7:0] ex_exp(exp_t e);
    return {e.alu_src, e.op, e.br, e.jal, e.jalr, e.mr, e.ill};
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, stepn, obs, exp);
    end
  endtask

  task automatic drive(bit v, logic [6:0] o, bit st, bit fl);
    bus.id_valid   = v;  bus.id_opcode  = o;  bus.stall  = st; bus.flush  = fl;
    bus0.id_valid  = v;  bus0.id_opcode = o;  bus0.stall = st; bus0.flush = fl;
  endtask

  // One clock: push the expected EX bundle, then check all taps after the edge.
  task automatic step(bit v, logic [6:0] o, bit st, bit fl);
    bit   acc;
    exp_t e, m, w;
    acc = v && !st && !fl && in_run;
    e   = acc ? dec(o) : '0;
    sb.push_back(e);
    if (acc && o == HALT) begin
      in_run = 1'b0;
      hstep  = stepn;
    end
    drive(v, o, st, fl);
    @(posedge clk);
    #1;
    m = (sb.size() >= 2) ? sb[sb.size()-2] : '0;
    w = (sb.size() >= 3) ? sb[sb.size()-3] : '0;
    chk("ex", ex_obs(), ex_exp(e));
    chk("mem", {6'd0, bus.mem_mem_read, bus.mem_mem_write}, {6'd0, m.mr, m.mw});
    chk("wb", {6'd0, bus.wb_reg_write, bus.wb_mem_to_reg}, {6'd0, w.rw, w.m2r});
    chk("fetch_en", {7'd0, bus.fetch_en}, {7'd0, in_run});
    chk("halted", {7'd0, bus.halted}, {7'd0, (!in_run && stepn >= hstep + N)});
    if (sb.size() > N) void'(sb.pop_front());
    stepn++;
  endtask

  task automatic do_reset();
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_fetch_en", {7'd0, bus.fetch_en}, 8'd1);
    chk("rst_halted", {7'd0, bus.halted}, 8'd0);
    chk("rst_ex", ex_obs(), 8'd0);
    chk("rst_memwb", {4'd0, bus.mem_mem_read, bus.mem_mem_write, bus.wb_reg_write,
                      bus.wb_mem_to_reg}, 8'd0);
    sb.delete();
    in_run = 1'b1;
    stepn  = 0;
    drive(1'b0, 7'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    drive(1'b0, 7'd0, 1'b0, 1'b0);
    #2;
    do_reset();

    // add: EX alu_op=10 next cycle, WB reg_write two cycles later
    step(1, ADD, 0, 0);
    chk("add_alu_op", {6'd0, bus.ex_alu_op}, 8'b10);
    step(0, 7'd0, 0, 0);
    step(0, 7'd0, 0, 0);
    chk("add_wb_rw", {7'd0, bus.wb_reg_write}, 8'd1);

    // lw then sw under stall -> bubble, sw accepted once stall drops
    step(1, LW, 0, 0);
    chk("lw_ex_mr", {7'd0, bus.ex_mem_read}, 8'd1);
    step(1, SW, 1, 0);
    chk("stall_bubble", ex_obs(), 8'd0);
    chk("lw_mem_mr", {7'd0, bus.mem_mem_read}, 8'd1);
    step(1, SW, 0, 0);
    step(0, 7'd0, 0, 0);
    chk("sw_mem_mw", {7'd0, bus.mem_mem_write}, 8'd1);

    // flushed jal never appears; stall+flush together also bubble
    step(1, JAL, 0, 1);
    step(1, JAL, 1, 1);
    step(0, 7'd0, 0, 0);
    step(0, 7'd0, 0, 0);

    // remaining decode classes
    step(1, ADDI, 0, 0);
    step(1, BEQ, 0, 0);
    step(1, JALR, 0, 0);
    step(1, LUI, 0, 0);
    chk("lui_u0_illegal", ex_obs0(), 8'h01);
    step(1, 7'b0000000, 0, 0);
    chk("zero_u0_illegal", ex_obs0(), 8'h01);
    step(1, JAL, 0, 0);
    step(0, 7'd0, 0, 0);
    step(0, 7'd0, 0, 0);

    // HALT with stall is not accepted
    step(1, HALT, 1, 0);
    step(1, HALT, 0, 1);

    // lw then HALT; adds afterwards must be ignored
    step(1, LW, 0, 0);
    step(1, HALT, 0, 0);
    for (int i = 0; i < 5; i++) step(1, ADD, 0, 0);
    chk("halted_sticky", {7'd0, bus.halted}, 8'd1);

    // reset two cycles into the drain
    do_reset();
    step(1, HALT, 0, 0);
    step(0, 7'd0, 0, 0);
    step(0, 7'd0, 0, 0);
    do_reset();
    step(1, ADD, 0, 0);
    step(0, 7'd0, 0, 0);
    step(0, 7'd0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
